// File: rtl/drain_pkg.sv
// Shared types and helpers for the output drain: FSM state encoding,
// a width-generic ReLU clamp and the word-counter width helper.
package drain_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      FLUSH
   } drain_state_t;

   localparam int RELU_MAX_WIDTH = 64;

   // Counter must be able to hold LENGTH itself, hence the +1.
   function automatic int cnt_width(input int length);
      return $clog2(length + 1);
   endfunction

   // Callers zero-extend a lane into RELU_MAX_WIDTH bits; width selects the sign bit.
   function automatic logic [RELU_MAX_WIDTH-1:0] relu(input logic [RELU_MAX_WIDTH-1:0] value,
                                                      input int width);
      logic sign;
      sign = 1'b0;
      for (int i = 0; i < RELU_MAX_WIDTH; i++) begin
         if (i == width - 1) sign = value[i];
      end
      return sign ? '0 : value;
   endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO whose head entry is read straight from register storage.
// Storage is cleared on reset so the head reads as zero until the first push.
module drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only honoured when the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/output_drain.sv
// Sequences the output serializer bank to capture one result tile and streams
// it out as packed beats. Define DRAIN_RELU_EN to clamp negative lanes to zero.
module output_drain
   import drain_pkg::*;
#(
   parameter int LENGTH     = 32,
   parameter int BIT_WIDTH  = 16,
   parameter int LANES      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       ser_write_enable,
   output logic                       ser_read_enable,
   input  logic [LANES*BIT_WIDTH-1:0] ser_out,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [LANES*BIT_WIDTH-1:0] m_data,
   output logic                       m_last
);

   localparam int DATA_W = LANES * BIT_WIDTH;
   localparam int CNT_W  = cnt_width(LENGTH);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

   drain_state_t      state;
   drain_state_t      next_state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] lane_data;
   logic [DATA_W:0]   head;
   logic              push;
   logic              pop;
   logic              last_push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;

`ifdef DRAIN_RELU_EN
   always_comb begin
      lane_data = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_data[k*BIT_WIDTH +: BIT_WIDTH] =
            BIT_WIDTH'(relu(RELU_MAX_WIDTH'(ser_out[k*BIT_WIDTH +: BIT_WIDTH]), BIT_WIDTH));
      end
   end
`else
   assign lane_data = ser_out;
`endif

   assign push      = ser_read_enable;
   assign pop       = m_valid && m_ready;
   assign last_push = push && (cnt == CNT_W'(LENGTH - 1));

   drain_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data ({last_push, lane_data}),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign m_valid = !fifo_empty;
   assign m_data  = head[DATA_W-1:0];
   assign m_last  = head[DATA_W] && m_valid;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // done trails the final handshake by one cycle, landing in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == FLUSH) && pop && m_last;
         if (state == LOAD)  cnt <= '0;
         else if (push)      cnt <= cnt + CNT_W'(1);
      end
   end

   // Shifting stalls only when the FIFO is full and nothing leaves this cycle.
   always_comb begin
      next_state       = state;
      ser_write_enable = 1'b0;
      ser_read_enable  = 1'b0;
      case (state)
         IDLE: begin
            if (start) next_state = LOAD;
         end
         LOAD: begin
            ser_write_enable = 1'b1;
            next_state       = DRAIN;
         end
         DRAIN: begin
            ser_read_enable = (fifo_count < FCNT_W'(FIFO_DEPTH)) || (fifo_full && pop);
            if (ser_read_enable && (cnt == CNT_W'(LENGTH - 1))) next_state = FLUSH;
         end
         FLUSH: begin
            if (pop && m_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: doc/output_drain.md
# output_drain

Downstream companion of the output serializer bank in the systolic-array result path. It sequences the serializers' `write_enable`/`read_enable` to capture one result tile and shift it out, LENGTH words per lane. It packs the LANES serializer outputs of each shift into one beat and delivers the beats over a valid/ready stream through a small FIFO. Downstream backpressure pauses shifting rather than dropping data.

## Interface
Parameters:
- `LENGTH`, 32: words per serializer, which is also beats per tile.
- `BIT_WIDTH`, 16: element width, signed two's complement.
- `LANES`, 32: number of serializers drained in parallel.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle pulse: tile results are stable on the serializer `in` buses.
- `busy`  out  1  high from the cycle after an accepted `start` through the cycle of the final handshake.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `ser_write_enable`  out  1  drives `write_enable` of all serializers.
- `ser_read_enable`  out  1  drives `read_enable` of all serializers.
- `ser_out`  in  LANES*BIT_WIDTH  concatenated serializer `out`; lane k is at bits [k*BIT_WIDTH +: BIT_WIDTH].
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  LANES*BIT_WIDTH  output beat.
- `m_last`  out  1  marks the LENGTH-th beat of a tile.

## Operation
- The FSM has four states: IDLE, LOAD, DRAIN, FLUSH.
- IDLE:
  - `start` → LOAD.
  - `start` in any other state is ignored.
- LOAD:
  - `ser_write_enable`=1 for exactly one cycle, then → DRAIN.
  - Clear the word counter `cnt` (width $clog2(LENGTH+1)).
- DRAIN:
  - `ser_read_enable` = (fifo_count < FIFO_DEPTH) OR (FIFO full AND pop this cycle).
  - Whenever `ser_read_enable`=1, push `ser_out` into the FIFO in the same cycle. The serializer output is the current top word, and the shift occurs at that edge.
  - `cnt` increments on each push. The push with `cnt`==LENGTH-1 tags its entry `last` and → FLUSH.
- FLUSH:
  - No serializer enables.
  - On the `m_valid & m_ready & m_last` handshake → IDLE.
  - `done`=1 in the following cycle, which is IDLE.
- `ser_write_enable` and `ser_read_enable` are never high in the same cycle.
- FIFO:
  - The head is presented registered on `m_data`/`m_last`.
  - `m_valid` = not empty. Pop on `m_valid & m_ready`.
  - Simultaneous push and pop when full is legal; count is unchanged.
- `m_data`/`m_last` hold stable while `m_valid & !m_ready`.
- `start` accepted in the `done` cycle begins a new tile normally.
- Reset, at any time including mid-DRAIN:
  - FSM returns to IDLE, FIFO empties, `cnt`=0.
  - All outputs go to 0: `busy`, `done`, `ser_write_enable`, `ser_read_enable`, `m_valid`, `m_last`, `m_data`.
  - Serializer contents are not touched; the next `start` reloads them.

## Timing
- `start` at cycle t:
  - `ser_write_enable` at t+1.
  - First `ser_read_enable` at t+2.
  - First `m_valid` at t+3.
- With `m_ready` held at 1, beats arrive on t+3 … t+LENGTH+2 and `m_last` is set at t+LENGTH+2.
- `done` and `busy`=0 occur at t+LENGTH+3. The end-to-end throughput is one beat per cycle.
- `busy`=1 from t+1 through t+LENGTH+2.
- A `m_ready` low for N cycles stalls shifting once the FIFO fills. No word is lost or duplicated.

## Configuration
- `DRAIN_RELU_EN` defined: each lane is clamped to 0 before the FIFO push if its sign bit is 1. This adds no latency.
- `DRAIN_RELU_EN` undefined: lanes pass through unchanged.

## Structure
- Package `drain_pkg` holds:
  - the state enum (IDLE, LOAD, DRAIN, FLUSH);
  - a `relu` function parameterized by width;
  - a localparam helper for counter width.
- Sub-module `drain_fifo`: a synchronous FIFO with registered head, `push`/`pop`/`full`/`empty`/`count`, reset asynchronously to empty. Its payload is LANES*BIT_WIDTH+1 bits (data plus `last`).
- The top level contains the FSM, the counter and the ReLU stage.

## Test plan
- **Basic drain.** LENGTH=4, LANES=2; serializers loaded with lane0 words 1,2,3,4 and lane1 words 10,20,30,40; `m_ready`=1.
  - Beats {10,1},{20,2},{30,3},{40,4} on consecutive cycles t+3…t+6.
  - `m_last` on the 4th beat; `done` at t+7.
- **Backpressure.** `m_ready`=0 from t+3 for 8 cycles, then 1.
  - `ser_read_enable` stops after FIFO_DEPTH pushes.
  - All 4 beats are delivered in order exactly once; `m_data` is stable while stalled.
- **Start while busy.** `start` pulsed at t+4.
  - Ignored: exactly LENGTH beats and one `done`.
  - `start` in the `done` cycle: a second tile starts; `ser_write_enable` in the next cycle.
- **Reset mid-DRAIN.** `rst` asserted for 1 cycle after 2 beats.
  - All outputs are 0 asynchronously; FIFO is empty.
  - A following `start` drains a full fresh tile.
- **ReLU.** Load lane word 16'hFFF6 (−10) and 16'h0005.
  - With `DRAIN_RELU_EN`: outputs 0 and 5.
  - Without it: outputs FFF6 and 0005.
- **Protocol check.** A bench assertion checks that `ser_write_enable & ser_read_enable` is never 1 in any scenario.
